aer_core_in_fifo: RTL and testbench

Per-core AER input buffer that sits directly downstream of the LRF mapper, one instance per core output channel. It accepts LRF-local events over the mapper's four-phase REQ/ACK channel and stores them in a first-word-fall-through FIFO. It presents them to the core's event decoder over a valid/ready interface, so a busy core stalls only its own channel and not the mapper's other outputs.

---
 rtl/aer_core_in_fifo.sv | 121 ++++++++++++
 tb/tb_aer_core_in_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_core_in_fifo.sv
// Per-core AER input buffer: four-phase REQ/ACK capture from the LRF mapper
// into a first-word-fall-through FIFO, drained over a valid/ready interface.
// Optional build macro AER_FIFO_REQ_SYNC_EN adds a 2-flop synchronizer on
// AERIN_REQ (reset to 0) in front of the input FSM.
module aer_core_in_fifo #(
  parameter int unsigned AER_WIDTH = 7,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 AERIN_REQ,
  input  logic [AER_WIDTH-1:0] AERIN_EVENT,
  input  logic [AER_WIDTH-3:0] AERIN_IDX,
  output logic                 AERIN_ACK,
  output logic                 EV_VALID,
  output logic [1:0]           EV_TYPE,
  output logic [AER_WIDTH-3:0] EV_IDX,
  input  logic                 EV_READY,
  output logic [CNT_W-1:0]     FIFO_COUNT,
  output logic                 FIFO_FULL
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AER_WIDTH-1:0] mem_q [DEPTH];
  logic [AER_WIDTH-1:0] wdata;
  logic [AER_WIDTH-1:0] head;
  logic                 req_s;
  logic                 push;
  logic                 pop;
  logic                 push_ok;

  // Only the type field of the event word is used.
  logic unused_event_bits;
  assign unused_event_bits = ^AERIN_EVENT[AER_WIDTH-3:0];

`ifdef AER_FIFO_REQ_SYNC_EN
  logic [1:0] req_sync_q;

  // Two-stage synchronizer for the asynchronous mapper request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= 2'b00;
    end else begin
      req_sync_q <= {req_sync_q[0], AERIN_REQ};
    end
  end

  assign req_s = req_sync_q[1];
`else
  assign req_s = AERIN_REQ;
`endif

  assign FIFO_COUNT = wr_ptr_q - rd_ptr_q;
  assign FIFO_FULL  = (FIFO_COUNT == CNT_W'(DEPTH));
  assign EV_VALID   = (FIFO_COUNT != '0);

  assign pop     = EV_VALID && EV_READY;
  // A pop on the same edge frees the slot the new event needs.
  assign push_ok = !FIFO_FULL || pop;
  assign push    = (state_q == StIdle) && req_s && push_ok;

  assign wdata = {AERIN_EVENT[AER_WIDTH-1 -: 2], AERIN_IDX};
  assign head  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign EV_TYPE   = head[AER_WIDTH-1 -: 2];
  assign EV_IDX    = head[AER_WIDTH-3:0];
  // ACK is exactly the registered HOLD state, so there is no path from EV_READY.
  assign AERIN_ACK = (state_q == StHold);

  // Next-state logic for the handshake FSM and both pointers.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (push) begin
          state_d  = StHold;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (!req_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  // State and pointer registers; buffered entries are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_aer_core_in_fifo.sv
// Self-checking bench for aer_core_in_fifo (DEPTH=4, AER_WIDTH=7).
module tb_aer_core_in_fifo;

  localparam int AW = 7;
  localparam int DP = 4;
  localparam int CW = 3;
`ifdef AER_FIFO_REQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [AW-1:0] ev_word;
  logic [AW-3:0] idx;
  logic          ack;
  logic          ev_valid;
  logic [1:0]    ev_type;
  logic [AW-3:0] ev_idx;
  logic          ev_ready;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;

  int total = 0;
  int bad   = 0;

  aer_core_in_fifo #(.AER_WIDTH(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AERIN_REQ  (req),
    .AERIN_EVENT(ev_word),
    .AERIN_IDX  (idx),
    .AERIN_ACK  (ack),
    .EV_VALID   (ev_valid),
    .EV_TYPE    (ev_type),
    .EV_IDX     (ev_idx),
    .EV_READY   (ev_ready),
    .FIFO_COUNT (fifo_count),
    .FIFO_FULL  (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic [1:0] t, input logic [4:0] i);
    ev_word = {t, 5'($urandom)};
    idx     = i;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    req      = 1'b0;
    ev_ready = 1'b0;
    drive_ev(2'b00, 5'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Counts edges until ACK reaches v, bounded by max.
  task automatic wait_ack(input logic v, input int max, output int n);
    n = 0;
    while (ack !== v && n < max) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic       req;
    logic       rdy;
    logic [1:0] typ;
    logic [4:0] idx;
    logic       e_ack;
    logic       e_valid;
    int         e_cnt;
    logic       e_full;
    logic [1:0] e_typ;
    logic [4:0] e_idx;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [1:0] t,
                              input logic [4:0] i, input logic a, input logic v, input int c,
                              input logic f, input logic [1:0] et, input logic [4:0] ei);
    vec_t x;
    x.req = r; x.rdy = rd; x.typ = t; x.idx = i;
    x.e_ack = a; x.e_valid = v; x.e_cnt = c; x.e_full = f; x.e_typ = et; x.e_idx = ei;
    return x;
  endfunction

  initial begin
    vec_t vecs[20];
    int   n;
    logic [6:0] q[$];
    logic [6:0] cur_ev;
    logic       m_hold, h0, h1, req_eff, m_pop, m_push;
    int         sent, outn, gap;

    rst_n = 1'b1;
    req = 1'b0;
    ev_ready = 1'b0;
    drive_ev(2'b00, 5'h00);
    #2;
    do_reset();
    check("reset_ack", ack, 0);
    check("reset_valid", ev_valid, 0);
    check("reset_count", fifo_count, 0);
    check("reset_full", fifo_full, 0);

`ifndef AER_FIFO_REQ_SYNC_EN
    // Single event, fill to full with a held 5th request, drain, pass-through.
    vecs[0]  = mk(1, 0, 2'd0, 5'h1A, 1, 1, 1, 0, 2'd0, 5'h1A);
    vecs[1]  = mk(0, 0, 2'd0, 5'h1A, 0, 1, 1, 0, 2'd0, 5'h1A);
    vecs[2]  = mk(1, 0, 2'd1, 5'h01, 1, 1, 2, 0, 2'd0, 5'h1A);
    vecs[3]  = mk(0, 0, 2'd1, 5'h01, 0, 1, 2, 0, 2'd0, 5'h1A);
    vecs[4]  = mk(1, 0, 2'd2, 5'h02, 1, 1, 3, 0, 2'd0, 5'h1A);
    vecs[5]  = mk(0, 0, 2'd2, 5'h02, 0, 1, 3, 0, 2'd0, 5'h1A);
    vecs[6]  = mk(1, 0, 2'd3, 5'h03, 1, 1, 4, 1, 2'd0, 5'h1A);
    vecs[7]  = mk(0, 0, 2'd3, 5'h03, 0, 1, 4, 1, 2'd0, 5'h1A);
    vecs[8]  = mk(1, 0, 2'd1, 5'h04, 0, 1, 4, 1, 2'd0, 5'h1A);
    vecs[9]  = mk(1, 0, 2'd1, 5'h04, 0, 1, 4, 1, 2'd0, 5'h1A);
    vecs[10] = mk(1, 1, 2'd1, 5'h04, 1, 1, 4, 1, 2'd1, 5'h01);
    vecs[11] = mk(0, 0, 2'd1, 5'h04, 0, 1, 4, 1, 2'd1, 5'h01);
    vecs[12] = mk(0, 1, 2'd0, 5'h00, 0, 1, 3, 0, 2'd2, 5'h02);
    vecs[13] = mk(0, 1, 2'd0, 5'h00, 0, 1, 2, 0, 2'd3, 5'h03);
    vecs[14] = mk(0, 1, 2'd0, 5'h00, 0, 1, 1, 0, 2'd1, 5'h04);
    vecs[15] = mk(0, 1, 2'd0, 5'h00, 0, 0, 0, 0, 2'd0, 5'h00);
    vecs[16] = mk(0, 1, 2'd0, 5'h00, 0, 0, 0, 0, 2'd0, 5'h00);
    vecs[17] = mk(1, 0, 2'd2, 5'h00, 1, 1, 1, 0, 2'd2, 5'h00);
    vecs[18] = mk(1, 0, 2'd2, 5'h00, 1, 1, 1, 0, 2'd2, 5'h00);
    vecs[19] = mk(0, 0, 2'd2, 5'h00, 0, 1, 1, 0, 2'd2, 5'h00);
    for (int i = 0; i < 20; i++) begin
      req      = vecs[i].req;
      ev_ready = vecs[i].rdy;
      drive_ev(vecs[i].typ, vecs[i].idx);
      tick();
      check($sformatf("vec%0d_ack", i), ack, vecs[i].e_ack);
      check($sformatf("vec%0d_valid", i), ev_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].e_cnt);
      check($sformatf("vec%0d_full", i), fifo_full, vecs[i].e_full);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_type", i), ev_type, vecs[i].e_typ);
        check($sformatf("vec%0d_idx", i), ev_idx, vecs[i].e_idx);
      end
    end
`endif

    // REQ-to-ACK latency in both directions.
    do_reset();
    drive_ev(2'b01, 5'h15);
    req = 1'b1;
    wait_ack(1'b1, 10, n);
    check("lat_rise", n, 1 + SYNC);
    req = 1'b0;
    wait_ack(1'b0, 10, n);
    check("lat_fall", n, 1 + SYNC);
    check("lat_count", fifo_count, 1);
    check("lat_idx", ev_idx, 5'h15);

    // Reset in the middle of a handshake with 3 entries buffered.
    do_reset();
    for (int e = 0; e < 3; e++) begin
      drive_ev(2'b11, 5'(e + 7));
      req = 1'b1;
      wait_ack(1'b1, 10, n);
      if (e < 2) begin
        req = 1'b0;
        wait_ack(1'b0, 10, n);
      end
    end
    check("mid_pre_ack", ack, 1);
    check("mid_pre_count", fifo_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_valid", ev_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    #2;
    rst_n = 1'b1;
    wait_ack(1'b1, 10, n);
    check("mid_recap_lat", n, 1 + SYNC);
    check("mid_recap_count", fifo_count, 1);
    check("mid_recap_type", ev_type, 2'b11);
    check("mid_recap_idx", ev_idx, 5'd9);
    req = 1'b0;
    wait_ack(1'b0, 10, n);
    check("mid_drop_ack", ack, 0);

    // Randomised stream of 20 events against a queue model.
    do_reset();
    q.delete();
    m_hold = 1'b0;
    h0 = 1'b0;
    h1 = 1'b0;
    sent = 0;
    outn = 0;
    gap = 0;
    cur_ev = '0;
    for (int cyc = 0; cyc < 3000 && outn < 20; cyc++) begin
      check("rnd_count", fifo_count, q.size());
      check("rnd_valid", ev_valid, q.size() != 0);
      check("rnd_ack", ack, m_hold);
      if (q.size() != 0) begin
        check("rnd_head", {ev_type, ev_idx}, q[0]);
      end
      // Mapper side of the four-phase handshake.
      if (!req && !ack && sent < 20 && gap == 0) begin
        cur_ev = {2'($urandom), 5'(sent)};
        drive_ev(cur_ev[6:5], cur_ev[4:0]);
        req = 1'b1;
      end else if (req && ack) begin
        req  = 1'b0;
        sent++;
        gap  = $urandom_range(0, 2);
      end else if (gap > 0) begin
        gap--;
      end
      ev_ready = 1'($urandom_range(0, 1));
      // Predict the coming edge.
      req_eff = (SYNC != 0) ? h1 : req;
      m_pop   = (q.size() != 0) && ev_ready;
      m_push  = !m_hold && req_eff && (q.size() < DP || m_pop);
      if (m_pop) begin
        check("rnd_order", ev_idx, outn);
        outn++;
        void'(q.pop_front());
      end
      if (m_push) begin
        q.push_back(cur_ev);
        m_hold = 1'b1;
      end else if (m_hold && !req_eff) begin
        m_hold = 1'b0;
      end
      h1 = h0;
      h0 = req;
      tick();
    end
    check("rnd_outputs", outn, 20);
    check("rnd_sent", sent, 20);
    check("rnd_final_count", fifo_count, q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
